// File: rtl/fpu_disp_pkg.sv
// ---------------------------------------------------------------------------
// fpu_disp_pkg
//   Shared types and constants for the fpu_sp_dispatch command front-end.
//   - CMD_FPU_SP_* opcodes, mirroring the values in fpu_parms.v
//   - disp_state_e : dispatcher FSM states
//   - fpu_req_t    : one queued request {cmd, din1, din2}
//   - is_legal_cmd : true for the five opcodes fpu_sp_top implements
// ---------------------------------------------------------------------------
package fpu_disp_pkg;

    localparam logic [3:0] CMD_FPU_SP_ADD = 4'h1;
    localparam logic [3:0] CMD_FPU_SP_MUL = 4'h2;
    localparam logic [3:0] CMD_FPU_SP_DIV = 4'h3;
    localparam logic [3:0] CMD_FPU_SP_I2F = 4'h4;
    localparam logic [3:0] CMD_FPU_SP_F2I = 4'h5;

    // Width of one FIFO entry: 4-bit opcode plus two 32-bit operands.
    localparam int REQ_W = 68;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } disp_state_e;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] din1;
        logic [31:0] din2;
    } fpu_req_t;

    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        logic legal;
        case (cmd)
            CMD_FPU_SP_ADD,
            CMD_FPU_SP_MUL,
            CMD_FPU_SP_DIV,
            CMD_FPU_SP_I2F,
            CMD_FPU_SP_F2I: legal = 1'b1;
            default:        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/fpu_disp_fifo.sv
// ---------------------------------------------------------------------------
// fpu_disp_fifo
//   Synchronous request FIFO, DEPTH x WIDTH, first-word-fall-through read
//   (rdata always shows the head entry).
//   Ports:
//     clk, rst       clock, asynchronous active-high reset (pointers only)
//     push, wdata    write one entry; ignored when full
//     pop            drop the head entry; ignored when empty
//     rdata          current head entry
//     full, empty    occupancy flags
//     count          number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fpu_disp_fifo
    import fpu_disp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = REQ_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    // NOTE: the storage array is deliberately not reset; only pointers and
    // count are, since an entry is never read before it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;   // power-of-two depth: natural wrap
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fpu_sp_dispatch.sv
// ---------------------------------------------------------------------------
// fpu_sp_dispatch
//   Command front-end for fpu_sp_top. Host requests are queued in a small
//   FIFO and issued one at a time (single dval pulse); the dispatcher waits
//   for rdy and hands the captured result back on a valid/ready port.
//   Strictly in order, at most one operation in flight.
//
//   Ports:
//     clk, rst                          clock, async active-high reset
//     req_valid/req_ready               host request handshake
//     req_cmd, req_din1, req_din2       request opcode and operands
//     fpu_cmd, fpu_din1, fpu_din2       to fpu_sp_top (held after issue)
//     fpu_dval                          one-cycle issue strobe
//     fpu_result, fpu_rdy               from fpu_sp_top
//     rsp_valid/rsp_ready               response handshake
//     rsp_cmd, rsp_result, rsp_err      completed opcode, result, error
//     busy                              queue non-empty or FSM not idle
//
//   Build option:
//     FPU_DISP_TIMEOUT_EN  abort WAIT with rsp_err=1 after TMO_CYCLES cycles
//                          without rdy; otherwise WAIT waits indefinitely.
// ---------------------------------------------------------------------------
module fpu_sp_dispatch
    import fpu_disp_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int TMO_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [31:0] req_din1,
    input  logic [31:0] req_din2,
    output logic [3:0]  fpu_cmd,
    output logic [31:0] fpu_din1,
    output logic [31:0] fpu_din2,
    output logic        fpu_dval,
    input  logic [31:0] fpu_result,
    input  logic        fpu_rdy,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_cmd,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYCLES < 1) begin : g_param_check
        $error("fpu_sp_dispatch: DEPTH must be a power of two >= 2, TMO_CYCLES >= 1");
    end

    disp_state_e      state_q;
    disp_state_e      state_d;
    fpu_req_t         head;
    fpu_req_t         hold_q;
    fpu_req_t         push_req;
    logic [REQ_W-1:0] fifo_rdata;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [AW:0]      count_nxt;
    logic             req_ready_q;
    logic             load_hold;
    logic             cap_result;
    logic             set_err;
    logic [31:0]      rsp_result_q;
    logic             rsp_err_q;
    logic             tmo_expired;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    assign push_req  = '{cmd: req_cmd, din1: req_din1, din2: req_din2};
    // req_ready_q already mirrors "not full"; the full term keeps the FIFO
    // safe even if that relationship is ever broken.
    assign fifo_push = req_valid && req_ready_q && !fifo_full;

    fpu_disp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (push_req),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head = fpu_req_t'(fifo_rdata);

    // req_ready is registered from the next-cycle occupancy. A pop while
    // full therefore cannot admit a push in the same cycle; ready only
    // rises on the following cycle.
    always_comb begin
        count_nxt = fifo_count;
        if (fifo_push && !fifo_pop) begin
            count_nxt = fifo_count + 1'b1;
        end else if (fifo_pop && !fifo_push) begin
            count_nxt = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q <= 1'b1;
        end else begin
            req_ready_q <= (count_nxt != FULL_CNT);
        end
    end

    // ------------------------------------------------------------------
    // WAIT timeout
    // ------------------------------------------------------------------
`ifdef FPU_DISP_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q;

    // Counts completed WAIT cycles; cleared in ISSUE so each operation
    // gets a full TMO_CYCLES window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WAIT && !tmo_expired) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_expired = (state_q == WAIT) && (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_expired = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Dispatcher FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here is given a default first, so no path
    // through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        load_hold  = 1'b0;
        cap_result = 1'b0;
        set_err    = 1'b0;
        fpu_dval   = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load_hold = 1'b1;
                    if (is_legal_cmd(head.cmd)) begin
                        state_d = ISSUE;
                    end else begin
                        // Illegal opcode never reaches the FPU.
                        set_err = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                fpu_dval = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // rdy has priority over an expiring timeout.
                if (fpu_rdy) begin
                    cap_result = 1'b1;
                    state_d    = RESP;
                end else if (tmo_expired) begin
                    set_err = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Holding and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (load_hold) begin
            hold_q <= head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else if (cap_result) begin
            rsp_result_q <= fpu_result;
            rsp_err_q    <= 1'b0;
        end else if (set_err) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
        end
    end

    // FPU operands come straight from the holding register, so they stay
    // put through WAIT and keep their last value in IDLE/RESP.
    assign fpu_cmd    = hold_q.cmd;
    assign fpu_din1   = hold_q.din1;
    assign fpu_din2   = hold_q.din2;
    assign rsp_cmd    = hold_q.cmd;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign req_ready  = req_ready_q;
    assign busy       = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: doc/fpu_sp_dispatch.md
Name: fpu_sp_dispatch

Overview:
- Command front-end sitting directly upstream of fpu_sp_top.
- Buffers host FPU requests in a small FIFO and issues them one at a time on fpu_sp_top's cmd/din1/din2/dval interface.
- Waits for rdy, then returns the captured result through a valid/ready response port.
- Lets a bus/host side stream operations without tracking FPU latency.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, minimum 2.
- TMO_CYCLES, 256, cycles to wait for rdy before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high (codebase clk/rst naming; polarity and synchronicity fixed)
- req_valid  in  1  host request valid
- req_ready  out  1  FIFO not full
- req_cmd  in  4  opcode, CMD_FPU_SP_* from fpu_parms.v
- req_din1  in  32  operand 1
- req_din2  in  32  operand 2, ignored for I2F/F2I
- fpu_cmd  out  4  to fpu_sp_top.cmd
- fpu_din1  out  32  to fpu_sp_top.din1
- fpu_din2  out  32  to fpu_sp_top.din2
- fpu_dval  out  1  to fpu_sp_top.dval
- fpu_result  in  32  from fpu_sp_top.result
- fpu_rdy  in  1  from fpu_sp_top.rdy
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_cmd  out  4  opcode of the completed operation
- rsp_result  out  32  FPU result; 0 on error
- rsp_err  out  1  illegal opcode or timeout
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset:
  - All outputs 0 except req_ready=1.
  - FIFO pointers and count cleared; FSM in IDLE.
  - Reset asserted mid-operation drops all queued and in-flight requests; no response is produced.
- Request push: occurs when req_valid && req_ready. req_ready = (count != DEPTH), registered.
- Simultaneous push and pop when full: push is refused that cycle; req_ready rises the next cycle.
- Pointers: log2(DEPTH) bits, natural wrap; a separate count of log2(DEPTH)+1 bits.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE:
    - FIFO non-empty: pop the head into the holding registers.
    - Legal opcode (ADD/MUL/DIV/I2F/F2I) -> ISSUE.
    - Illegal opcode -> RESP with rsp_err=1, rsp_result=0; nothing issued to the FPU.
  - ISSUE:
    - fpu_dval=1 for exactly one cycle.
    - fpu_cmd/din1/din2 driven from the holding registers.
    - -> WAIT.
  - WAIT:
    - fpu_cmd/din1/din2 held stable and fpu_dval=0 until fpu_rdy.
    - On fpu_rdy: capture fpu_result into rsp_result, rsp_err=0 -> RESP.
    - fpu_rdy in any state other than WAIT is ignored.
  - RESP:
    - rsp_valid=1; rsp_cmd/result/err held stable until rsp_ready.
    - On handshake: rsp_valid drops next cycle -> IDLE.
    - No back-to-back bypass: minimum one IDLE cycle between responses.
- Ordering: strictly in order, at most one operation in flight.
- Latency, FIFO empty, request -> rsp_valid:
  - Push cycle (entry written, count=1).
  - IDLE pop.
  - ISSUE.
  - WAIT: N cycles, where N is the FPU's dval-to-rdy latency.
  - RESP: rsp_valid asserted.
- fpu_cmd/din outputs retain their last value in IDLE/RESP; they are not zeroed.
- busy = (count != 0) || (state != IDLE).

Optional Feature:
- FPU_DISP_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT; it clears on entering WAIT.
  - If fpu_rdy is not seen within TMO_CYCLES cycles -> RESP with rsp_err=1, rsp_result=0.
  - fpu_rdy arriving the same cycle the counter expires: the result wins, err=0.
  - A late fpu_rdy after the abort is ignored.
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Shared package fpu_disp_pkg:
  - FSM state enum (IDLE/ISSUE/WAIT/RESP).
  - Request struct {cmd[3:0], din1[31:0], din2[31:0]}.
  - Function is_legal_cmd() built on the CMD_FPU_SP_* constants from fpu_parms.v.
- One sub-module: fpu_disp_fifo.
  - Synchronous FIFO, DEPTH x 68 bits.
  - push/pop/full/empty/count.
  - Async active-high reset on pointers only.

Test Plan:
- ADD: req 3f800000 + 40000000 -> one fpu_dval pulse, then rsp_result=40400000, rsp_err=0, rsp_cmd=CMD_FPU_SP_ADD.
- Back-to-back MUL 40000000*40400000, DIV 40c00000/40000000, I2F 00000005, F2I 40a00000, pushed on consecutive cycles:
  - Responses in order: 40c00000, 40400000, 40a00000, 00000005.
  - fpu_din stable through each WAIT.
- Full FIFO: DEPTH=4 with rsp_ready=0; push 6 requests.
  - req_ready drops after the 5th (4 queued plus 1 held in RESP).
  - The 6th stalls until the first response handshake, then is accepted with no loss.
- Illegal opcode 4'hF followed by ADD:
  - First response rsp_err=1, rsp_result=0, with no fpu_dval pulse.
  - Second response is the correct ADD result.
- Reset mid-WAIT: assert rst while 2 requests are queued.
  - All outputs return to reset values; req_ready=1; busy=0.
  - No rsp_valid is seen after reset release.
- FPU_DISP_TIMEOUT_EN, TMO_CYCLES=16, FPU model never raises rdy:
  - rsp_err=1 after 16 WAIT cycles.
  - A later spurious fpu_rdy produces no response.
